// File: rtl/sayeh_pkg.sv
// Shared SAYEH sequencer definitions: sequencer state encoding, datapath word
// width and the default reset/interrupt vectors.
package sayeh_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_VECTOR = 16'h0000;
    localparam logic [WORD_W-1:0] DEFAULT_IRQ_VECTOR   = 16'h0001;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/execute bus between the PC sequencer, instruction memory and the execute unit.
// Interrupt signals exist only when PC_SEQUENCER_IRQ_EN is defined.
interface pc_sequencer_if;
    import sayeh_pkg::*;

    logic              mem_rd;
    logic [WORD_W-1:0] mem_addr;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_data;
    logic [WORD_W-1:0] ir;
    logic              ir_valid;
    logic              exec_done;
    logic              jmp_abs;
    logic              jmp_rel;
    logic [WORD_W-1:0] jmp_target;
    logic              halt;
    logic              halted;
    logic [WORD_W-1:0] pc;
`ifdef PC_SEQUENCER_IRQ_EN
    logic              irq;
    logic              irq_ack;
    logic [WORD_W-1:0] epc;
`endif

    modport master (
        output mem_rd, mem_addr, ir, ir_valid, halted, pc,
`ifdef PC_SEQUENCER_IRQ_EN
        output irq_ack, epc,
        input  irq,
`endif
        input  mem_ready, mem_data, exec_done, jmp_abs, jmp_rel, jmp_target, halt
    );

    modport slave (
        input  mem_rd, mem_addr, ir, ir_valid, halted, pc,
`ifdef PC_SEQUENCER_IRQ_EN
        input  irq_ack, epc,
        output irq,
`endif
        output mem_ready, mem_data, exec_done, jmp_abs, jmp_rel, jmp_target, halt
    );

endinterface

// File: rtl/pc_sequencer_pc_reg.sv
// Program-counter register: load-enabled word register with an asynchronous
// active-low reset to a configurable value.
module pc_reg
    import sayeh_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VALUE = DEFAULT_RESET_VECTOR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/halt program-counter sequencer for the SAYEH core.
// Define PC_SEQUENCER_IRQ_EN to compile in interrupt entry (irq/irq_ack/epc).
module pc_sequencer
    import sayeh_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
`ifdef PC_SEQUENCER_IRQ_EN
    ,
    parameter logic [WORD_W-1:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    seq_state_e        state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              pc_en;
    logic [WORD_W-1:0] redirect_pc;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
`ifdef PC_SEQUENCER_IRQ_EN
    logic [WORD_W-1:0] epc_q, epc_d;
    logic              irq_ack_q, irq_ack_d;
`endif

    pc_reg #(
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_en       = 1'b0;
        ir_d        = ir_q;
        ir_valid_d  = 1'b0;
`ifdef PC_SEQUENCER_IRQ_EN
        epc_d       = epc_q;
        irq_ack_d   = 1'b0;
`endif
        // Relative jumps are taken from the already-incremented pc.
        redirect_pc = pc_q;
        if (bus.jmp_abs) begin
            redirect_pc = bus.jmp_target;
        end else if (bus.jmp_rel) begin
            redirect_pc = pc_q + bus.jmp_target;
        end

        unique case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d       = bus.mem_data;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + 16'd1;
                    pc_en      = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.exec_done) begin
                    if (bus.halt) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = redirect_pc;
                        pc_en   = 1'b1;
`ifdef PC_SEQUENCER_IRQ_EN
                        if (bus.irq) begin
                            epc_d     = redirect_pc;
                            pc_d      = IRQ_VECTOR;
                            irq_ack_d = 1'b1;
                        end
`endif
                    end
                end
            end
            ST_HALT: begin
`ifdef PC_SEQUENCER_IRQ_EN
                if (bus.irq) begin
                    epc_d     = pc_q;
                    pc_d      = IRQ_VECTOR;
                    pc_en     = 1'b1;
                    irq_ack_d = 1'b1;
                    state_d   = ST_FETCH;
                end
`endif
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
`ifdef PC_SEQUENCER_IRQ_EN
            epc_q      <= '0;
            irq_ack_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
`ifdef PC_SEQUENCER_IRQ_EN
            epc_q      <= epc_d;
            irq_ack_q  <= irq_ack_d;
`endif
        end
    end

    // The fetch request is masked while reset is held so memory sees no read.
    assign bus.mem_rd   = (state_q == ST_FETCH) && rst_n;
    assign bus.mem_addr = pc_q;
    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.halted   = (state_q == ST_HALT);
`ifdef PC_SEQUENCER_IRQ_EN
    assign bus.irq_ack  = irq_ack_q;
    assign bus.epc      = epc_q;
`endif

endmodule
